// File: rtl/mux_channel_scanner.sv
// Sequencer around a 4:1 mux: walks enabled channels in ascending order, waits a settle time,
// captures mux_o and offers each bit tagged with its channel over a valid/ready handshake.
module mux_channel_scanner #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter bit          CONTINUOUS    = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic [3:0] en_mask,
    input  logic       mux_o,
    output logic [1:0] sel,
    output logic       busy,
    output logic       sample_valid,
    input  logic       sample_ready,
    output logic       sample_data,
    output logic [1:0] sample_ch,
    output logic       frame_done
);

    localparam int unsigned CntW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StSettle, StPresent} state_e;

    state_e          r_state, w_state_nxt;
    logic [3:0]      r_mask, w_mask_nxt;
    logic [1:0]      r_sel, w_sel_nxt;
    logic [CntW-1:0] r_cnt, w_cnt_nxt;
    logic            r_valid, w_valid_nxt;
    logic            r_data, w_data_nxt;
    logic [1:0]      r_ch, w_ch_nxt;
    logic            r_done, w_done_nxt;
    logic            r_stop_pending, w_stop_pending_nxt;
    logic            w_stop_eff;

    function automatic logic [1:0] f_lowest(input logic [3:0] m);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (m[i]) r = 2'(i);
        end
        return r;
    endfunction

    function automatic logic f_has_above(input logic [3:0] m, input logic [1:0] s);
        logic r;
        r = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (m[i] && (i > int'(s))) r = 1'b1;
        end
        return r;
    endfunction

    function automatic logic [1:0] f_next_above(input logic [3:0] m, input logic [1:0] s);
        logic [1:0] r;
        r = s;
        for (int i = 3; i >= 0; i--) begin
            if (m[i] && (i > int'(s))) r = 2'(i);
        end
        return r;
    endfunction

    // A stop arriving in the very handshake cycle terminates just like a pending one.
    assign w_stop_eff = stop | r_stop_pending;

    always_comb begin
        w_state_nxt        = r_state;
        w_mask_nxt         = r_mask;
        w_sel_nxt          = r_sel;
        w_cnt_nxt          = r_cnt;
        w_valid_nxt        = r_valid;
        w_data_nxt         = r_data;
        w_ch_nxt           = r_ch;
        w_done_nxt         = 1'b0;
        w_stop_pending_nxt = r_stop_pending;

        case (r_state)
            StIdle: begin
                w_stop_pending_nxt = 1'b0;
                if (start && (en_mask != 4'd0)) begin
                    w_mask_nxt  = en_mask;
                    w_sel_nxt   = f_lowest(en_mask);
                    w_cnt_nxt   = '0;
                    w_state_nxt = StSettle;
                end
            end
            StSettle: begin
                if (stop) begin
                    w_stop_pending_nxt = 1'b0;
                    w_state_nxt        = StIdle;
                end else if (r_cnt == CntLast) begin
                    w_data_nxt  = mux_o;
                    w_ch_nxt    = r_sel;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = StPresent;
                end else begin
                    w_cnt_nxt = r_cnt + CntW'(1);
                end
            end
            StPresent: begin
                if (sample_ready) begin
                    w_valid_nxt = 1'b0;
                    if (f_has_above(r_mask, r_sel)) begin
                        if (w_stop_eff) begin
                            w_stop_pending_nxt = 1'b0;
                            w_state_nxt        = StIdle;
                        end else begin
                            w_sel_nxt   = f_next_above(r_mask, r_sel);
                            w_cnt_nxt   = '0;
                            w_state_nxt = StSettle;
                        end
                    end else begin
                        w_done_nxt = 1'b1;
                        if (CONTINUOUS && !w_stop_eff && (en_mask != 4'd0)) begin
                            w_mask_nxt  = en_mask;
                            w_sel_nxt   = f_lowest(en_mask);
                            w_cnt_nxt   = '0;
                            w_state_nxt = StSettle;
                        end else begin
                            w_stop_pending_nxt = 1'b0;
                            w_state_nxt        = StIdle;
                        end
                    end
                end else if (stop) begin
                    w_stop_pending_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= StIdle;
            r_mask         <= 4'd0;
            r_sel          <= 2'd0;
            r_cnt          <= '0;
            r_valid        <= 1'b0;
            r_data         <= 1'b0;
            r_ch           <= 2'd0;
            r_done         <= 1'b0;
            r_stop_pending <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_mask         <= w_mask_nxt;
            r_sel          <= w_sel_nxt;
            r_cnt          <= w_cnt_nxt;
            r_valid        <= w_valid_nxt;
            r_data         <= w_data_nxt;
            r_ch           <= w_ch_nxt;
            r_done         <= w_done_nxt;
            r_stop_pending <= w_stop_pending_nxt;
        end
    end

    assign sel          = r_sel;
    assign busy         = (r_state != StIdle);
    assign sample_valid = r_valid;
    assign sample_data  = r_data;
    assign sample_ch    = r_ch;
    assign frame_done   = r_done;

endmodule

// File: tb/tb_mux_channel_scanner.sv
// Bench: one-shot and continuous scanners driven in parallel, each checked cycle by cycle
// against a channel-list reference model.
module tb_mux_channel_scanner;

    localparam int unsigned Settle = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0, stop = 1'b0, ready = 1'b0;
    logic [3:0] en_mask = 4'd0, mux_in = 4'd0;
    logic [1:0] sel0, ch0, sel1, ch1;
    logic       busy0, v0, d0, fd0, busy1, v1, d1, fd1;
    logic       mo0, mo1;

    assign mo0 = mux_in[sel0];
    assign mo1 = mux_in[sel1];

    always #5 clk = ~clk;

    mux_channel_scanner #(.SETTLE_CYCLES(Settle), .CONTINUOUS(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .en_mask(en_mask),
        .mux_o(mo0), .sel(sel0), .busy(busy0), .sample_valid(v0), .sample_ready(ready),
        .sample_data(d0), .sample_ch(ch0), .frame_done(fd0)
    );

    mux_channel_scanner #(.SETTLE_CYCLES(Settle), .CONTINUOUS(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .en_mask(en_mask),
        .mux_o(mo1), .sel(sel1), .busy(busy1), .sample_valid(v1), .sample_ready(ready),
        .sample_data(d1), .sample_ch(ch1), .frame_done(fd1)
    );

    int compared = 0;
    int mismatched = 0;
    int acc1 = 0, done0 = 0, done1 = 0;

    // Reference model: phase 0 idle, 1 settling, 2 presenting; channels kept as an ordered list.
    int m_phase[2], m_sel[2], m_ch[2], m_left[2], m_len[2], m_pos[2];
    int m_list[2][4];
    bit m_valid[2], m_data[2], m_done[2], m_sp[2];

    task automatic build(input int i, input logic [3:0] m);
        m_len[i] = 0;
        for (int c = 0; c < 4; c++) begin
            if (m[c]) begin
                m_list[i][m_len[i]] = c;
                m_len[i]++;
            end
        end
        m_pos[i]   = 0;
        m_sel[i]   = m_list[i][0];
        m_left[i]  = Settle;
        m_phase[i] = 1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_phase[i] = 0; m_sel[i] = 0; m_ch[i] = 0; m_left[i] = 0;
            m_len[i] = 0; m_pos[i] = 0; m_valid[i] = 0; m_data[i] = 0;
            m_done[i] = 0; m_sp[i] = 0;
        end
    endtask

    task automatic model_step(input int i, input bit cont);
        m_done[i] = 0;
        case (m_phase[i])
            0: if (start && en_mask != 4'd0) build(i, en_mask);
            1: begin
                if (stop) begin
                    m_phase[i] = 0;
                    m_sp[i]    = 0;
                end else begin
                    m_left[i]--;
                    if (m_left[i] == 0) begin
                        m_valid[i] = 1;
                        m_data[i]  = mux_in[m_sel[i]];
                        m_ch[i]    = m_sel[i];
                        m_phase[i] = 2;
                    end
                end
            end
            2: begin
                if (ready) begin
                    m_valid[i] = 0;
                    if (m_pos[i] + 1 < m_len[i]) begin
                        m_pos[i]++;
                        if (stop || m_sp[i]) begin
                            m_phase[i] = 0;
                            m_sp[i]    = 0;
                        end else begin
                            m_sel[i]   = m_list[i][m_pos[i]];
                            m_left[i]  = Settle;
                            m_phase[i] = 1;
                        end
                    end else begin
                        m_done[i] = 1;
                        if (cont && !(stop || m_sp[i]) && en_mask != 4'd0) begin
                            build(i, en_mask);
                        end else begin
                            m_phase[i] = 0;
                            m_sp[i]    = 0;
                        end
                    end
                end else if (stop) begin
                    m_sp[i] = 1;
                end
            end
            default: m_phase[i] = 0;
        endcase
    endtask

    task automatic check(input int i);
        logic [7:0] obs, exp;
        obs = (i == 0) ? {sel0, busy0, v0, d0, ch0, fd0} : {sel1, busy1, v1, d1, ch1, fd1};
        exp = {m_sel[i][1:0], (m_phase[i] != 0), m_valid[i], m_data[i], m_ch[i][1:0],
               m_done[i]};
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL out%0d observed=%b expected=%b at %0t", i, obs, exp, $time);
        end
    endtask

    task automatic expect_int(input string tag, input int obs, input int exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic cycle();
        model_step(0, 1'b0);
        model_step(1, 1'b1);
        if (v1 && ready) acc1++;
        @(posedge clk);
        #1;
        if (fd0) done0++;
        if (fd1) done1++;
        check(0);
        check(1);
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; ready = 1'b0;
        model_reset();
        #1;
        check(0);
        check(1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        acc1 = 0; done0 = 0; done1 = 0;
    endtask

    initial begin
        int found;
        do_reset();

        // Basic frame: mask 1011, inputs 0110 -> (0,0) (1,1) (3,0)
        en_mask = 4'b1011; mux_in = 4'b0110; ready = 1'b1;
        pulse_start();
        run(20);
        expect_int("frame_a_done", done0, 1);
        expect_int("frame_a_busy", int'(busy0), 0);

        // Backpressure on ch1 for five cycles
        do_reset();
        en_mask = 4'b1011; mux_in = 4'b0110; ready = 1'b1;
        pulse_start();
        found = 0;
        for (int k = 0; k < 30; k++) begin
            if (v0 && ch0 == 2'd1) begin found = 1; break; end
            cycle();
        end
        expect_int("bp_found_ch1", found, 1);
        ready = 1'b0;
        run(5);
        expect_int("bp_sel_held", int'(sel0), 1);
        ready = 1'b1;
        run(15);
        expect_int("bp_done", done0, 1);

        // Empty mask ignored, then single channel
        do_reset();
        en_mask = 4'b0000; ready = 1'b1;
        pulse_start();
        run(5);
        expect_int("empty_busy", int'(busy0), 0);
        en_mask = 4'b0100; mux_in = 4'b0100;
        pulse_start();
        run(10);
        expect_int("single_done", done0, 1);

        // Continuous with stop during second ch1 presentation
        do_reset();
        en_mask = 4'b0011; mux_in = 4'b0010; ready = 1'b1;
        pulse_start();
        found = 0;
        for (int k = 0; k < 60; k++) begin
            if (v1 && ch1 == 2'd1 && acc1 == 3) begin found = 1; break; end
            cycle();
        end
        expect_int("cont_found", found, 1);
        stop = 1'b1;
        cycle();
        stop = 1'b0;
        run(15);
        expect_int("cont_samples", acc1, 4);
        expect_int("cont_frames", done1, 2);
        expect_int("cont_busy", int'(busy1), 0);

        // Stop during ch1 settle
        do_reset();
        en_mask = 4'b0011; mux_in = 4'b0011; ready = 1'b1;
        pulse_start();
        found = 0;
        for (int k = 0; k < 30; k++) begin
            if (busy0 && sel0 == 2'd1 && !v0) begin found = 1; break; end
            cycle();
        end
        expect_int("abort_found", found, 1);
        stop = 1'b1;
        cycle();
        stop = 1'b0;
        run(5);
        expect_int("abort_done", done0, 0);

        // Asynchronous reset while a sample is held
        do_reset();
        en_mask = 4'b0101; mux_in = 4'b1111; ready = 1'b0;
        pulse_start();
        found = 0;
        for (int k = 0; k < 20; k++) begin
            if (v0) begin found = 1; break; end
            cycle();
        end
        expect_int("rst_found_valid", found, 1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check(0);
        check(1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        done0 = 0; done1 = 0; acc1 = 0;
        en_mask = 4'b0110; mux_in = 4'b0100; ready = 1'b1;
        pulse_start();
        run(20);
        expect_int("post_rst_done", done0, 1);

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            start   = ($urandom % 8) == 0;
            stop    = ($urandom % 32) == 0;
            en_mask = 4'($urandom);
            ready   = ($urandom % 4) != 0;
            mux_in  = 4'($urandom);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
